// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg
// Shared definitions for the FIFO drain arbiter: the arbitration state
// encoding, the width of the per-burst pop counter and a saturating
// increment helper for that counter.
//
// Optional feature macro used elsewhere in this slice:
//   FIFO_DRAIN_ARBITER_STATS_EN - adds per-port accepted-word counters.
package fifo_drain_pkg;

    // Arbiter is either waiting for any upstream FIFO to hold data, or
    // draining the granted port.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Width of the pop counter inside one burst.
    localparam int BURST_CNT_W = 8;

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [BURST_CNT_W-1:0] sat_inc(
        input logic [BURST_CNT_W-1:0] cnt,
        input logic [BURST_CNT_W-1:0] limit
    );
        return (cnt >= limit) ? limit : cnt + BURST_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fifo_drain_arbiter_if.sv
// fifo_drain_arbiter_if
// Bundles the upstream FIFO read side and the downstream valid/ready stream
// of the FIFO drain arbiter.
//
// Signals:
//   fifo_empty     - per-port empty flag of each upstream FIFO
//   fifo_dout      - per-port FIFO data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_shift_out - per-port pop strobe, at most one bit high
//   m_data/m_port  - downstream word and the port it came from
//   m_valid/m_ready- downstream handshake
// Modports: master = the arbiter, slave = its environment.
interface fifo_drain_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int PORT_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]            fifo_empty;
    logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_dout;
    logic [NUM_PORTS-1:0]            fifo_shift_out;
    logic [DATA_WIDTH-1:0]           m_data;
    logic [PORT_W-1:0]               m_port;
    logic                            m_valid;
    logic                            m_ready;

    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_shift_out, m_data, m_port, m_valid
    );

    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_shift_out, m_data, m_port, m_valid
    );

endinterface

// File: rtl/fifo_drain_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin winner search. Starting at ptr+1 and wrapping
// through ptr itself, returns the first requesting index both one-hot and
// binary encoded. Both outputs are zero when nothing requests.
//
// Ports:
//   req       - request vector
//   ptr       - index of the previous winner
//   grant_oh  - one-hot winner
//   grant_idx - binary winner index
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant_oh,
    output logic [$clog2(N)-1:0] grant_idx
);

    // Walk the candidates from the farthest (ptr itself) to the nearest
    // (ptr+1); the last hit overwrites earlier ones, so the nearest
    // requester after the pointer wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                grant_oh                       = '0;
                grant_oh[(int'(ptr) + k) % N]  = 1'b1;
                grant_idx = ($clog2(N))'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter
// Drains NUM_PORTS upstream first-word-fall-through-less FIFOs (read latency
// 1) into one valid/ready stream. Ports are served round-robin in bursts of
// up to BURST_LEN pops. Popped words land in a 2-entry output buffer; pops
// are only issued when the buffer plus the word in flight leaves room, so
// back-pressure never loses data.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   bus        - fifo_drain_arbiter_if.master (FIFO side + downstream stream)
//   stat_words - per-port accepted-word counters, 32 bits each
//                (only with FIFO_DRAIN_ARBITER_STATS_EN defined)
module fifo_drain_arbiter
    import fifo_drain_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    fifo_drain_arbiter_if.master    bus
`ifdef FIFO_DRAIN_ARBITER_STATS_EN
    ,
    output logic [NUM_PORTS*32-1:0] stat_words
`endif
);

    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(BURST_LEN);

    state_e                  state_q, state_d;
    logic [PORT_W-1:0]       last_grant_q, last_grant_d;
    logic [BURST_CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic                    inflight_q, inflight_d;
    logic [PORT_W-1:0]       inflight_port_q, inflight_port_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [PORT_W-1:0]       out_port_q, out_port_d;
    logic                    skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
    logic [PORT_W-1:0]       skid_port_q, skid_port_d;

    logic [NUM_PORTS-1:0]    req_vec;
    logic [NUM_PORTS-1:0]    pick_oh;
    logic [PORT_W-1:0]       pick_idx;
    logic                    pick_any;
    logic                    accept;
    logic [1:0]              slots_used;
    logic                    grant_empty;
    logic                    pop;
    logic [NUM_PORTS-1:0]    shift_vec;
    logic [DATA_WIDTH-1:0]   in_data;

    // A port requests service whenever its FIFO holds data. The search
    // always starts just after the last granted port, which also lets a
    // lone busy port be re-granted straight away.
    assign req_vec = ~bus.fifo_empty;

    rr_pick #(
        .N (NUM_PORTS)
    ) u_rr_pick (
        .req       (req_vec),
        .ptr       (last_grant_q),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx)
    );

    assign pick_any = |pick_oh;

    // Pop qualification. A slot counts as used if it holds a word or a word
    // is on its way from last cycle's pop; a word leaving downstream this
    // cycle frees its slot immediately so a single port can stream at full
    // rate. Pops stop while reset is asserted so nothing is lost upstream
    // during reset beyond what was already in flight.
    always_comb begin
        accept      = out_valid_q && bus.m_ready;
        slots_used  = {1'b0, out_valid_q} + {1'b0, skid_valid_q}
                    + {1'b0, inflight_q} - {1'b0, accept};
        grant_empty = bus.fifo_empty[last_grant_q];
        pop         = !rst && (state_q == BURST) && !grant_empty
                    && (slots_used < 2'd2) && (burst_cnt_q < BURST_LIMIT);
        shift_vec   = '0;
        shift_vec[last_grant_q] = pop;
    end

    // Arbitration state. The grant is re-evaluated either when the granted
    // FIFO shows empty or in the same cycle the last pop of a burst goes
    // out, so a full burst hands over without a dead cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d      = BURST;
                    last_grant_d = pick_idx;
                    burst_cnt_d  = '0;
                end
            end
            BURST: begin
                if (grant_empty) begin
                    state_d      = pick_any ? BURST : IDLE;
                    last_grant_d = pick_any ? pick_idx : last_grant_q;
                    burst_cnt_d  = '0;
                end else if (pop) begin
                    burst_cnt_d = sat_inc(burst_cnt_q, BURST_LIMIT);
                    if (burst_cnt_d == BURST_LIMIT) begin
                        state_d      = pick_any ? BURST : IDLE;
                        last_grant_d = pick_any ? pick_idx : last_grant_q;
                        burst_cnt_d  = '0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Output buffer: the head register drives the stream directly, the skid
    // register catches the one extra word that can arrive while the head is
    // stalled. Words always move skid -> head, keeping pop order.
    always_comb begin
        in_data         = bus.fifo_dout[int'(inflight_port_q)*DATA_WIDTH +: DATA_WIDTH];
        inflight_d      = pop;
        inflight_port_d = last_grant_q;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        out_port_d      = out_port_q;
        skid_valid_d    = skid_valid_q;
        skid_data_d     = skid_data_q;
        skid_port_d     = skid_port_q;
        if (!out_valid_q || accept) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_port_d   = skid_port_q;
                skid_valid_d = inflight_q;
                if (inflight_q) begin
                    skid_data_d = in_data;
                    skid_port_d = inflight_port_q;
                end
            end else if (inflight_q) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
                out_port_d  = inflight_port_q;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (inflight_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_port_d  = inflight_port_q;
        end
    end

    // All state lives here. Reset empties the buffer and drops the word in
    // flight, and points last_grant at the top port so port 0 is served
    // first afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            last_grant_q    <= PORT_W'(NUM_PORTS - 1);
            burst_cnt_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_port_q <= '0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_port_q      <= '0;
            skid_valid_q    <= 1'b0;
            skid_data_q     <= '0;
            skid_port_q     <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            burst_cnt_q     <= burst_cnt_d;
            inflight_q      <= inflight_d;
            inflight_port_q <= inflight_port_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_port_q      <= out_port_d;
            skid_valid_q    <= skid_valid_d;
            skid_data_q     <= skid_data_d;
            skid_port_q     <= skid_port_d;
        end
    end

    // Outputs are forced quiet for the whole reset cycle, not just after
    // the reset edge.
    assign bus.fifo_shift_out = shift_vec;
    assign bus.m_valid        = out_valid_q && !rst;
    assign bus.m_data         = rst ? '0 : out_data_q;
    assign bus.m_port         = rst ? '0 : out_port_q;

`ifdef FIFO_DRAIN_ARBITER_STATS_EN
    logic [31:0] stat_cnt_q [NUM_PORTS];

    // One free-running counter per port, bumped on every downstream accept
    // of a word from that port; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                stat_cnt_q[i] <= '0;
            end
        end else if (accept) begin
            stat_cnt_q[out_port_q] <= stat_cnt_q[out_port_q] + 32'd1;
        end
    end

    // Flatten the counters onto the output bus, port i at [i*32 +: 32].
    always_comb begin
        stat_words = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            stat_words[i*32 +: 32] = stat_cnt_q[i];
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb_fifo_drain_arbiter
// Self-checking bench for fifo_drain_arbiter. Upstream FIFOs are modelled as
// queues with one cycle read latency; each port's expected output stream is
// simply the words loaded into it, in order. Define
// FIFO_DRAIN_ARBITER_STATS_EN to also exercise the stat_words counters.
module tb_fifo_drain_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int BL = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_drain_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();

`ifdef FIFO_DRAIN_ARBITER_STATS_EN
    logic [NP*32-1:0] stat_words;
`endif

    fifo_drain_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef FIFO_DRAIN_ARBITER_STATS_EN
        ,
        .stat_words (stat_words)
`endif
    );

    logic [DW-1:0] fq   [NP][$];
    logic [DW-1:0] expq [NP][$];
    logic [DW-1:0] dout_r [NP];

    int checks, passes, fails;
    int cyc, outstanding;
    int pop_port[$], pop_cyc[$], valid_cyc[$], acc_port[$];

    logic [NP-1:0] last_shift;
    logic          last_rst;
    logic          prev_valid, prev_ready, prev_rst;
    logic [DW-1:0] prev_data;
    logic [1:0]    prev_port;
    logic          samp_valid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic refresh();
        for (int p = 0; p < NP; p++) begin
            bus.fifo_empty[p]          = (fq[p].size() == 0);
            bus.fifo_dout[p*DW +: DW]  = dout_r[p];
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int p = 0; p < NP; p++) s += expq[p].size();
        return s;
    endfunction

    task automatic clearLogs();
        pop_port.delete();
        pop_cyc.delete();
        valid_cyc.delete();
        acc_port.delete();
    endtask

    // Load n random words into one upstream FIFO.
    task automatic applyStimulus(input int port, input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom();
            fq[port].push_back(w);
            expq[port].push_back(w);
        end
        refresh();
    endtask

    // Per-cycle checks, sampled mid-cycle.
    task automatic checkOutput();
        logic [NP-1:0] sh;
        logic [1:0]    mp;
        sh = bus.fifo_shift_out;
        chk("shift_onehot0", 64'($onehot0(sh)), 64'(1));
        chk("shift_on_empty", 64'(sh & bus.fifo_empty), 64'(0));
        chk("buffer_bound", 64'(outstanding <= 2), 64'(1));
        if (rst) begin
            chk("rst_m_valid", 64'(bus.m_valid), 64'(0));
            chk("rst_m_data", 64'(bus.m_data), 64'(0));
            chk("rst_m_port", 64'(bus.m_port), 64'(0));
            chk("rst_shift", 64'(sh), 64'(0));
        end else if (prev_valid && !prev_ready && !prev_rst) begin
            chk("stall_valid", 64'(bus.m_valid), 64'(1));
            chk("stall_data", 64'(bus.m_data), 64'(prev_data));
            chk("stall_port", 64'(bus.m_port), 64'(prev_port));
        end
        for (int p = 0; p < NP; p++) begin
            if (sh[p]) begin
                pop_port.push_back(p);
                pop_cyc.push_back(cyc);
            end
        end
        if (!rst && bus.m_valid) valid_cyc.push_back(cyc);
        if (!rst && bus.m_valid && bus.m_ready) begin
            mp = bus.m_port;
            acc_port.push_back(int'(mp));
            chk("word_expected", 64'(expq[mp].size() > 0), 64'(1));
            if (expq[mp].size() > 0) begin
                chk($sformatf("data_port%0d", mp), 64'(bus.m_data), 64'(expq[mp].pop_front()));
            end
            outstanding--;
        end
        last_shift = sh;
        last_rst   = rst;
        prev_valid = bus.m_valid;
        prev_ready = bus.m_ready;
        prev_rst   = rst;
        prev_data  = bus.m_data;
        prev_port  = bus.m_port;
        samp_valid = bus.m_valid;
    endtask

    // One clock cycle: check mid-cycle, then let the FIFO model respond to
    // the pops it saw.
    task automatic tick();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < NP; p++) begin
            if (last_shift[p] && fq[p].size() > 0) begin
                dout_r[p] = fq[p].pop_front();
                outstanding++;
            end
        end
        if (last_rst) begin
            for (int p = 0; p < NP; p++) expq[p] = fq[p];
            outstanding = 0;
        end
        refresh();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(pending()), 64'(0));
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clearLogs();
    endtask

    // Expected port order with everything preloaded and no back-pressure:
    // bursts of up to BL words, next burst from the next busy port after
    // the previous one, starting at port 0.
    task automatic rrOrder(input int cnt[NP], output int ord[$]);
        int rem[NP];
        int p, n, total;
        ord.delete();
        rem = cnt;
        p = 0;
        total = 0;
        for (int i = 0; i < NP; i++) total += rem[i];
        while (total > 0) begin
            while (rem[p] == 0) p = (p + 1) % NP;
            n = (rem[p] < BL) ? rem[p] : BL;
            for (int k = 0; k < n; k++) ord.push_back(p);
            rem[p] -= n;
            total -= n;
            p = (p + 1) % NP;
        end
    endtask

    initial begin
        int cnt[NP];
        int ord[$];
        int n;
        checks = 0; passes = 0; fails = 0;
        cyc = 0; outstanding = 0;
        last_shift = '0; last_rst = 1'b1;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_rst = 1'b1;
        prev_data = '0; prev_port = '0; samp_valid = 1'b0;
        rst = 1'b1;
        bus.m_ready = 1'b0;
        for (int p = 0; p < NP; p++) dout_r[p] = '0;
        refresh();

        // Reset state
        doReset();
        tick();
        chk("idle_after_reset", 64'(samp_valid), 64'(0));

        // Lone port 1 with 3 words: back-to-back pops, valid 2..4 after first pop
        bus.m_ready = 1'b1;
        applyStimulus(1, 3);
        drain("drain_lone", 50);
        chk("lone_pop_count", 64'(pop_cyc.size()), 64'(3));
        chk("lone_valid_count", 64'(valid_cyc.size()), 64'(3));
        if (pop_cyc.size() == 3 && valid_cyc.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("lone_pop_port[%0d]", k), 64'(pop_port[k]), 64'(1));
                chk($sformatf("lone_pop_cyc[%0d]", k), 64'(pop_cyc[k]), 64'(pop_cyc[0] + k));
                chk($sformatf("lone_valid_cyc[%0d]", k), 64'(valid_cyc[k]), 64'(pop_cyc[0] + 2 + k));
            end
        end

        // Ports 0 and 2 with 6 words each, full rate
        doReset();
        bus.m_ready = 1'b1;
        cnt = '{6, 0, 6, 0};
        applyStimulus(0, 6);
        applyStimulus(2, 6);
        drain("drain_two_port", 100);
        rrOrder(cnt, ord);
        chk("order_len", 64'(acc_port.size()), 64'(ord.size()));
        for (int i = 0; i < ord.size() && i < acc_port.size(); i++) begin
            chk($sformatf("order[%0d]", i), 64'(acc_port[i]), 64'(ord[i]));
        end

        // Back-pressure for 10 cycles in the middle of a burst
        doReset();
        bus.m_ready = 1'b1;
        applyStimulus(3, 8);
        n = 0;
        while (acc_port.size() < 1 && n < 20) begin tick(); n++; end
        chk("stall_first_word", 64'(acc_port.size()), 64'(1));
        bus.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 2) chk($sformatf("stall_no_pop[%0d]", i), 64'(last_shift), 64'(0));
        end
        bus.m_ready = 1'b1;
        drain("drain_stall", 60);
        chk("stall_all_words", 64'(acc_port.size()), 64'(8));

        // Reset pulsed mid-burst; port 0 must win afterwards
        doReset();
        bus.m_ready = 1'b1;
        applyStimulus(2, 6);
        n = 0;
        while (acc_port.size() < 2 && n < 30) begin tick(); n++; end
        chk("pre_rst_words", 64'(acc_port.size()), 64'(2));
        rst = 1'b1;
        applyStimulus(0, 2);
        tick();
        rst = 1'b0;
        clearLogs();
        tick();
        chk("post_rst_valid", 64'(samp_valid), 64'(0));
        drain("drain_post_rst", 100);
        chk("post_rst_pops", 64'(pop_port.size() > 0), 64'(1));
        if (pop_port.size() > 0) chk("post_rst_first_grant", 64'(pop_port[0]), 64'(0));

        // Port 3 runs dry after 2 pops of a burst, grant moves on
        doReset();
        bus.m_ready = 1'b1;
        applyStimulus(3, 2);
        n = 0;
        while (pop_port.size() < 1 && n < 20) begin tick(); n++; end
        applyStimulus(0, 3);
        drain("drain_dry", 60);
        ord = '{3, 3, 0, 0, 0};
        chk("dry_len", 64'(acc_port.size()), 64'(5));
        for (int i = 0; i < 5 && i < acc_port.size(); i++) begin
            chk($sformatf("dry_order[%0d]", i), 64'(acc_port[i]), 64'(ord[i]));
        end

        // Random traffic with random back-pressure
        for (int r = 0; r < 4; r++) begin
            doReset();
            for (int p = 0; p < NP; p++) applyStimulus(p, $urandom_range(0, 7));
            for (int i = 0; i < 150; i++) begin
                bus.m_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 19) == 0) applyStimulus($urandom_range(0, NP - 1), $urandom_range(1, 3));
                tick();
            end
            bus.m_ready = 1'b1;
            drain($sformatf("drain_random[%0d]", r), 300);
        end

`ifdef FIFO_DRAIN_ARBITER_STATS_EN
        // Accepted-word statistics
        doReset();
        bus.m_ready = 1'b1;
        applyStimulus(1, 5);
        drain("drain_stats", 50);
        tick();
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("stat_words[%0d]", p), 64'(stat_words[p*32 +: 32]), 64'((p == 1) ? 5 : 0));
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
